decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
//  Decoder end of the DC->DP interface. Takes raw 32-bit RV32I words from fetch, decodes them into
//  the internal 7-bit opcode enum plus rs1/rs2/rd/imm, and buffers them in an in-order FIFO.
//  Serves one entry per dispatcher query (DP2DC_query_inst) as a one-cycle DC2DP_en pulse.
//  Sits between the fetch unit and the dispatcher.
// PARAMETERS
//  ADDR_WIDTH   32  pc width
//  REG_WIDTH    5   architectural register index width
//  QUEUE_WIDTH  3   log2 FIFO depth (DEPTH = 1<<QUEUE_WIDTH = 8)
// PORTS
//  clk_in            in   1           clock
//  rst_in            in   1           asynchronous, active-low reset
//  rdy_in            in   1           global ready; low = freeze all state
//  IF2DC_en          in   1           raw instruction valid this cycle
//  IF2DC_pc          in   ADDR_WIDTH  pc of raw instruction
//  IF2DC_inst        in   32          raw instruction word
//  DC2IF_full        out  1           fetch must not push next cycle
//  RoB2DC_clear      in   1           flush (mispredict): drop everything
//  DP2DC_query_inst  in   1           dispatcher requests one instruction
//  DC2DP_en          out  1           decoded instruction valid (1-cycle pulse)
//  DC2DP_pc          out  ADDR_WIDTH  pc
//  DC2DP_opcode      out  7           enum: LUI=1 ... AND=37 (dispatcher table); 0 = illegal
//  DC2DP_rs1         out  REG_WIDTH   0 when unused (LUI/AUIPC/JAL)
//  DC2DP_rs2         out  REG_WIDTH   0 when unused (non-branch/store/R-type)
//  DC2DP_rd          out  REG_WIDTH   0 for branches/stores
//  DC2DP_imm         out  32          sign-extended I/S/B/U/J imm; SLLI/SRLI/SRAI: zero-ext shamt; R-type: 0
// BEHAVIOUR
//  - Reset (rst_in=0, async): all outputs 0; head/tail/count 0; state IDLE.
//  - rdy_in=0: no register changes (outputs hold; dispatcher shares rdy_in).
//  - Decode is combinational at enqueue; FIFO stores decoded fields.
//    Unknown opcode/funct3/funct7 -> opcode 0, other fields 0; still enqueued and served in order.
//  - Push: IF2DC_en && count<DEPTH -> write tail, tail++ (wraps mod DEPTH). Push at count==DEPTH is dropped.
//  - DC2IF_full = (count >= DEPTH-1), combinational from count (one slot of slack for fetch).
//  - FSM IDLE / WAIT:
//    IDLE: query && count>0 -> at edge load output regs from head, pop, DC2DP_en=1 next cycle.
//          query && count==0 -> WAIT.
//    WAIT: count>0 -> serve head as above, return to IDLE. Further queries in WAIT are ignored.
//  - DC2DP_en clears the cycle after its pulse unless a new serve occurs; data regs hold when en=0.
//  - Latency: query with non-empty FIFO -> DC2DP_en in the next cycle.
//  - Simultaneous push+pop: both occur, count unchanged. Push into empty FIFO is visible to
//    the serve logic from the following cycle.
//  - Priority: RoB2DC_clear > serve > push. Clear: head=tail=count=0, state IDLE,
//    DC2DP_en=0 next cycle; a same-cycle push or query is discarded.
// CONFIGURATION
//  DC_BYPASS_EN defined: in WAIT with count==0 and IF2DC_en, the incoming decoded instruction
//    loads the output regs directly (not enqueued); DC2DP_en in the next cycle (1-cycle latency).
//  DC_BYPASS_EN undefined: instruction is enqueued first; DC2DP_en two cycles after the push.
// TESTING
//  1 Hold rst_in=0 mid-traffic -> all outputs 0 immediately; DC2IF_full=0; FIFO empty after release.
//  2 Push 0x00500093 at pc 0x0, then query -> DC2DP_en 1 cycle: opcode 0010011 (ADDI), rs1 0,
//    rs2 0, rd 1, imm 5.
//  3 Push 0xFE208EE3 at pc 0x100 -> BEQ: opcode 5, rs1 1, rs2 2, rd 0, imm 0xFFFFFFFC;
//    push 0xFFFFFFFF -> opcode 0.
//  4 Query on empty FIFO, push at t -> DC2DP_en at t+2 (macro off) or t+1 (DC_BYPASS_EN on);
//    exactly one pulse.
//  5 Push 8 instructions with no query -> DC2IF_full high at count 7; 9th push dropped;
//    8 queries return pcs in push order.
//  6 FIFO holds 3 entries; clear + push + query in the same cycle -> no DC2DP_en, count 0,
//    state IDLE; next push+query works.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: RV32I decoder feeding an in-order 2^QUEUE_WIDTH-entry FIFO;
// one decoded entry is handed to the dispatcher per query as a DC2DP_en pulse.
// Build option DC_BYPASS_EN: an instruction arriving while the dispatcher waits
// on an empty queue goes straight to the output registers (1-cycle latency).
module decode_queue #(
  parameter int ADDR_WIDTH  = 32,
  parameter int REG_WIDTH   = 5,
  parameter int QUEUE_WIDTH = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  IF2DC_en,
  input  logic [ADDR_WIDTH-1:0] IF2DC_pc,
  input  logic [31:0]           IF2DC_inst,
  output logic                  DC2IF_full,
  input  logic                  RoB2DC_clear,
  input  logic                  DP2DC_query_inst,
  output logic                  DC2DP_en,
  output logic [ADDR_WIDTH-1:0] DC2DP_pc,
  output logic [6:0]            DC2DP_opcode,
  output logic [REG_WIDTH-1:0]  DC2DP_rs1,
  output logic [REG_WIDTH-1:0]  DC2DP_rs2,
  output logic [REG_WIDTH-1:0]  DC2DP_rd,
  output logic [31:0]           DC2DP_imm
);

  localparam int DEPTH = 1 << QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH:0] COUNT_DEPTH = (QUEUE_WIDTH+1)'(DEPTH);
  localparam logic [QUEUE_WIDTH:0] COUNT_FULL  = (QUEUE_WIDTH+1)'(DEPTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [6:0]            opcode;
    logic [REG_WIDTH-1:0]  rs1;
    logic [REG_WIDTH-1:0]  rs2;
    logic [REG_WIDTH-1:0]  rd;
    logic [31:0]           imm;
  } entry_t;

  entry_t                 mem [DEPTH];
  entry_t                 dec;
  entry_t                 out_reg, out_next;
  logic                   en_reg, en_next;
  logic [QUEUE_WIDTH-1:0] head_reg, head_next;
  logic [QUEUE_WIDTH-1:0] tail_reg, tail_next;
  logic [QUEUE_WIDTH:0]   count_reg, count_next;
  logic [0:0]             state_reg, state_next;
  logic                   do_serve, do_bypass, do_push;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign f3     = IF2DC_inst[14:12];
  assign f7     = IF2DC_inst[31:25];
  assign imm_i  = {{20{IF2DC_inst[31]}}, IF2DC_inst[31:20]};
  assign imm_s  = {{20{IF2DC_inst[31]}}, IF2DC_inst[31:25], IF2DC_inst[11:7]};
  assign imm_b  = {{19{IF2DC_inst[31]}}, IF2DC_inst[31], IF2DC_inst[7],
                   IF2DC_inst[30:25], IF2DC_inst[11:8], 1'b0};
  assign imm_u  = {IF2DC_inst[31:12], 12'h000};
  assign imm_j  = {{11{IF2DC_inst[31]}}, IF2DC_inst[31], IF2DC_inst[19:12],
                   IF2DC_inst[20], IF2DC_inst[30:21], 1'b0};
  assign imm_sh = {27'd0, IF2DC_inst[24:20]};

  // Decode the incoming raw word into the dispatcher enum; illegal -> all-zero fields
  always_comb begin
    dec     = '0;
    dec.pc  = IF2DC_pc;
    case (IF2DC_inst[6:0])
      7'b0110111: begin dec.opcode = 7'd1; dec.rd = REG_WIDTH'(IF2DC_inst[11:7]); dec.imm = imm_u; end
      7'b0010111: begin dec.opcode = 7'd2; dec.rd = REG_WIDTH'(IF2DC_inst[11:7]); dec.imm = imm_u; end
      7'b1101111: begin dec.opcode = 7'd3; dec.rd = REG_WIDTH'(IF2DC_inst[11:7]); dec.imm = imm_j; end
      7'b1100111: begin
        if (f3 == 3'b000) dec.opcode = 7'd4;
        dec.rd  = REG_WIDTH'(IF2DC_inst[11:7]);
        dec.rs1 = REG_WIDTH'(IF2DC_inst[19:15]);
        dec.imm = imm_i;
      end
      7'b1100011: begin
        case (f3)
          3'b000:  dec.opcode = 7'd5;
          3'b001:  dec.opcode = 7'd6;
          3'b100:  dec.opcode = 7'd7;
          3'b101:  dec.opcode = 7'd8;
          3'b110:  dec.opcode = 7'd9;
          3'b111:  dec.opcode = 7'd10;
          default: dec.opcode = 7'd0;
        endcase
        dec.rs1 = REG_WIDTH'(IF2DC_inst[19:15]);
        dec.rs2 = REG_WIDTH'(IF2DC_inst[24:20]);
        dec.imm = imm_b;
      end
      7'b0000011: begin
        case (f3)
          3'b000:  dec.opcode = 7'd11;
          3'b001:  dec.opcode = 7'd12;
          3'b010:  dec.opcode = 7'd13;
          3'b100:  dec.opcode = 7'd14;
          3'b101:  dec.opcode = 7'd15;
          default: dec.opcode = 7'd0;
        endcase
        dec.rd  = REG_WIDTH'(IF2DC_inst[11:7]);
        dec.rs1 = REG_WIDTH'(IF2DC_inst[19:15]);
        dec.imm = imm_i;
      end
      7'b0100011: begin
        case (f3)
          3'b000:  dec.opcode = 7'd16;
          3'b001:  dec.opcode = 7'd17;
          3'b010:  dec.opcode = 7'd18;
          default: dec.opcode = 7'd0;
        endcase
        dec.rs1 = REG_WIDTH'(IF2DC_inst[19:15]);
        dec.rs2 = REG_WIDTH'(IF2DC_inst[24:20]);
        dec.imm = imm_s;
      end
      7'b0010011: begin
        dec.rd  = REG_WIDTH'(IF2DC_inst[11:7]);
        dec.rs1 = REG_WIDTH'(IF2DC_inst[19:15]);
        dec.imm = imm_i;
        case (f3)
          3'b000: dec.opcode = 7'd19;
          3'b010: dec.opcode = 7'd20;
          3'b011: dec.opcode = 7'd21;
          3'b100: dec.opcode = 7'd22;
          3'b110: dec.opcode = 7'd23;
          3'b111: dec.opcode = 7'd24;
          3'b001: begin
            dec.imm = imm_sh;
            if (f7 == 7'b0000000) dec.opcode = 7'd25;
          end
          default: begin
            dec.imm = imm_sh;
            if (f7 == 7'b0000000)      dec.opcode = 7'd26;
            else if (f7 == 7'b0100000) dec.opcode = 7'd27;
          end
        endcase
      end
      7'b0110011: begin
        dec.rd  = REG_WIDTH'(IF2DC_inst[11:7]);
        dec.rs1 = REG_WIDTH'(IF2DC_inst[19:15]);
        dec.rs2 = REG_WIDTH'(IF2DC_inst[24:20]);
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.opcode = 7'd28;
            3'b001:  dec.opcode = 7'd30;
            3'b010:  dec.opcode = 7'd31;
            3'b011:  dec.opcode = 7'd32;
            3'b100:  dec.opcode = 7'd33;
            3'b101:  dec.opcode = 7'd34;
            3'b110:  dec.opcode = 7'd36;
            default: dec.opcode = 7'd37;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      dec.opcode = 7'd29;
          else if (f3 == 3'b101) dec.opcode = 7'd35;
        end
      end
      default: dec.opcode = 7'd0;
    endcase
    if (dec.opcode == 7'd0) begin
      dec.rs1 = '0;
      dec.rs2 = '0;
      dec.rd  = '0;
      dec.imm = '0;
    end
  end

  // Serve/wait FSM: clear beats serve, serve beats push
  always_comb begin
    do_serve   = 1'b0;
    do_bypass  = 1'b0;
    state_next = state_reg;
    if (RoB2DC_clear) begin
      state_next = IDLE;
    end else if (state_reg == IDLE) begin
      if (DP2DC_query_inst) begin
        if (count_reg != '0) do_serve = 1'b1;
        else                 state_next = WAIT;
      end
    end else begin
      if (count_reg != '0) begin
        do_serve   = 1'b1;
        state_next = IDLE;
      end
`ifdef DC_BYPASS_EN
      else if (IF2DC_en) begin
        do_bypass  = 1'b1;
        state_next = IDLE;
      end
`endif
    end
  end

  assign do_push    = IF2DC_en && !RoB2DC_clear && !do_bypass && (count_reg < COUNT_DEPTH);
  assign DC2IF_full = (count_reg >= COUNT_FULL);

  // Pointer and occupancy update; a same-cycle push and pop leave count unchanged
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (RoB2DC_clear) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (do_serve) head_next = head_reg + 1'b1;
      if (do_push)  tail_next = tail_reg + 1'b1;
      case ({do_push, do_serve})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // Output register next value: a serve or bypass pulses en, otherwise data holds
  always_comb begin
    en_next  = 1'b0;
    out_next = out_reg;
    if (do_serve) begin
      en_next  = 1'b1;
      out_next = mem[head_reg];
    end else if (do_bypass) begin
      en_next  = 1'b1;
      out_next = dec;
    end
  end

  // FIFO storage write; entries need no reset because count gates validity
  always_ff @(posedge clk_in) begin
    if (rdy_in && do_push) mem[tail_reg] <= dec;
  end

  // State registers; rdy_in low freezes everything
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      state_reg <= IDLE;
      en_reg    <= 1'b0;
      out_reg   <= '0;
    end else if (rdy_in) begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      state_reg <= state_next;
      en_reg    <= en_next;
      out_reg   <= out_next;
    end
  end

  assign DC2DP_en     = en_reg;
  assign DC2DP_pc     = out_reg.pc;
  assign DC2DP_opcode = out_reg.opcode;
  assign DC2DP_rs1    = out_reg.rs1;
  assign DC2DP_rs2    = out_reg.rs2;
  assign DC2DP_rd     = out_reg.rd;
  assign DC2DP_imm    = out_reg.imm;

endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed scenarios plus randomized traffic against a
// queue-based reference model with a table-driven RV32I decoder.
module tb_decode_queue;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        IF2DC_en;
  logic [31:0] IF2DC_pc;
  logic [31:0] IF2DC_inst;
  logic        DC2IF_full;
  logic        RoB2DC_clear;
  logic        DP2DC_query_inst;
  logic        DC2DP_en;
  logic [31:0] DC2DP_pc;
  logic [6:0]  DC2DP_opcode;
  logic [4:0]  DC2DP_rs1, DC2DP_rs2, DC2DP_rd;
  logic [31:0] DC2DP_imm;

`ifdef DC_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  decode_queue dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .IF2DC_en(IF2DC_en), .IF2DC_pc(IF2DC_pc), .IF2DC_inst(IF2DC_inst),
    .DC2IF_full(DC2IF_full), .RoB2DC_clear(RoB2DC_clear),
    .DP2DC_query_inst(DP2DC_query_inst), .DC2DP_en(DC2DP_en),
    .DC2DP_pc(DC2DP_pc), .DC2DP_opcode(DC2DP_opcode), .DC2DP_rs1(DC2DP_rs1),
    .DC2DP_rs2(DC2DP_rs2), .DC2DP_rd(DC2DP_rd), .DC2DP_imm(DC2DP_imm)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
  } ent_t;

  typedef struct {
    logic [6:0] opc;
    int         f3;
    int         f7;
    logic [6:0] id;
    byte        fmt;
  } pat_t;

  pat_t       pats [40];
  int         n_pats = 0;
  logic [6:0] raw_opcs [9];

  ent_t mq[$];
  ent_t exp_out;
  bit   exp_en;
  bit   waiting;

  int checks = 0;
  int failures = 0;

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic add_pat(logic [6:0] opc, int f3, int f7, logic [6:0] id, byte fmt);
    pats[n_pats] = '{opc, f3, f7, id, fmt};
    n_pats++;
  endtask

  // Mnemonic table: raw opcode, funct3/funct7 (-1 = don't care), enum id, format
  task automatic build_table();
    add_pat(7'b0110111, -1, -1, 7'd1, "U"); add_pat(7'b0010111, -1, -1, 7'd2, "U");
    add_pat(7'b1101111, -1, -1, 7'd3, "J"); add_pat(7'b1100111, 0, -1, 7'd4, "I");
    add_pat(7'b1100011, 0, -1, 7'd5, "B");  add_pat(7'b1100011, 1, -1, 7'd6, "B");
    add_pat(7'b1100011, 4, -1, 7'd7, "B");  add_pat(7'b1100011, 5, -1, 7'd8, "B");
    add_pat(7'b1100011, 6, -1, 7'd9, "B");  add_pat(7'b1100011, 7, -1, 7'd10, "B");
    add_pat(7'b0000011, 0, -1, 7'd11, "I"); add_pat(7'b0000011, 1, -1, 7'd12, "I");
    add_pat(7'b0000011, 2, -1, 7'd13, "I"); add_pat(7'b0000011, 4, -1, 7'd14, "I");
    add_pat(7'b0000011, 5, -1, 7'd15, "I"); add_pat(7'b0100011, 0, -1, 7'd16, "S");
    add_pat(7'b0100011, 1, -1, 7'd17, "S"); add_pat(7'b0100011, 2, -1, 7'd18, "S");
    add_pat(7'b0010011, 0, -1, 7'd19, "I"); add_pat(7'b0010011, 2, -1, 7'd20, "I");
    add_pat(7'b0010011, 3, -1, 7'd21, "I"); add_pat(7'b0010011, 4, -1, 7'd22, "I");
    add_pat(7'b0010011, 6, -1, 7'd23, "I"); add_pat(7'b0010011, 7, -1, 7'd24, "I");
    add_pat(7'b0010011, 1, 0, 7'd25, "H");  add_pat(7'b0010011, 5, 0, 7'd26, "H");
    add_pat(7'b0010011, 5, 32, 7'd27, "H");
    add_pat(7'b0110011, 0, 0, 7'd28, "R");  add_pat(7'b0110011, 0, 32, 7'd29, "R");
    add_pat(7'b0110011, 1, 0, 7'd30, "R");  add_pat(7'b0110011, 2, 0, 7'd31, "R");
    add_pat(7'b0110011, 3, 0, 7'd32, "R");  add_pat(7'b0110011, 4, 0, 7'd33, "R");
    add_pat(7'b0110011, 5, 0, 7'd34, "R");  add_pat(7'b0110011, 5, 32, 7'd35, "R");
    add_pat(7'b0110011, 6, 0, 7'd36, "R");  add_pat(7'b0110011, 7, 0, 7'd37, "R");
    raw_opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                 7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
  endtask

  function automatic ent_t ref_decode(logic [31:0] pc, logic [31:0] w);
    ent_t        e;
    logic [12:0] b;
    logic [20:0] j;
    logic [11:0] s;
    e    = '0;
    e.pc = pc;
    for (int i = 0; i < n_pats; i++) begin
      if (pats[i].opc == w[6:0] &&
          (pats[i].f3 < 0 || pats[i].f3 == int'(w[14:12])) &&
          (pats[i].f7 < 0 || pats[i].f7 == int'(w[31:25]))) begin
        e.op = pats[i].id;
        case (pats[i].fmt)
          "U": begin e.rd = w[11:7]; e.imm = {w[31:12], 12'h000}; end
          "J": begin
            e.rd = w[11:7];
            j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
            e.imm = 32'($signed(j));
          end
          "I": begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = 32'($signed(w[31:20])); end
          "H": begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.imm = 32'(w[24:20]); end
          "B": begin
            e.rs1 = w[19:15]; e.rs2 = w[24:20];
            b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
            e.imm = 32'($signed(b));
          end
          "S": begin
            e.rs1 = w[19:15]; e.rs2 = w[24:20];
            s = {w[31:25], w[11:7]};
            e.imm = 32'($signed(s));
          end
          default: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
        endcase
        break;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          r;
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r < 3) return w;
    w[6:0] = raw_opcs[$urandom_range(0, 8)];
    if (r < 6) w[31:25] = 7'h00;
    else if (r < 8) w[31:25] = 7'h20;
    return w;
  endfunction

  // Reference behaviour at one rising edge, from the pre-edge inputs
  task automatic model_step();
    ent_t d;
    int   sz;
    bit   byp;
    if (!rdy_in) return;
    if (RoB2DC_clear) begin
      mq.delete();
      waiting = 1'b0;
      exp_en  = 1'b0;
      return;
    end
    sz     = mq.size();
    byp    = 1'b0;
    exp_en = 1'b0;
    d      = ref_decode(IF2DC_pc, IF2DC_inst);
    if (!waiting) begin
      if (DP2DC_query_inst) begin
        if (sz > 0) begin exp_out = mq.pop_front(); exp_en = 1'b1; end
        else waiting = 1'b1;
      end
    end else if (sz > 0) begin
      exp_out = mq.pop_front(); exp_en = 1'b1; waiting = 1'b0;
    end else if (BYPASS && IF2DC_en) begin
      exp_out = d; exp_en = 1'b1; waiting = 1'b0; byp = 1'b1;
    end
    if (IF2DC_en && !byp && sz < 8) mq.push_back(d);
  endtask

  task automatic model_reset();
    mq.delete();
    waiting = 1'b0;
    exp_en  = 1'b0;
    exp_out = '0;
  endtask

  task automatic compare_all();
    check_val("en",     DC2DP_en,     exp_en);
    check_val("pc",     DC2DP_pc,     exp_out.pc);
    check_val("opcode", DC2DP_opcode, exp_out.op);
    check_val("rs1",    DC2DP_rs1,    exp_out.rs1);
    check_val("rs2",    DC2DP_rs2,    exp_out.rs2);
    check_val("rd",     DC2DP_rd,     exp_out.rd);
    check_val("imm",    DC2DP_imm,    exp_out.imm);
    check_val("full",   DC2IF_full,   mq.size() >= 7);
    if (exp_en)
      $display("serve pc=%08h op=%0d rs1=%0d rs2=%0d rd=%0d imm=%08h",
               exp_out.pc, exp_out.op, exp_out.rs1, exp_out.rs2, exp_out.rd, exp_out.imm);
  endtask

  task automatic cycle(bit en, logic [31:0] pc, logic [31:0] inst, bit q, bit clr, bit rdy);
    IF2DC_en = en; IF2DC_pc = pc; IF2DC_inst = inst;
    DP2DC_query_inst = q; RoB2DC_clear = clr; rdy_in = rdy;
    @(posedge clk_in);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push(logic [31:0] pc, logic [31:0] inst);
    cycle(1'b1, pc, inst, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic query();
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic random_cycles(int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 99) < 55, $urandom, rand_inst(),
            $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 90);
  endtask

  initial begin
    int first, pulses, exp_lat;
    build_table();
    rst_in = 1'b0; rdy_in = 1'b1; IF2DC_en = 1'b0; IF2DC_pc = '0; IF2DC_inst = '0;
    RoB2DC_clear = 1'b0; DP2DC_query_inst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    compare_all();
    rst_in = 1'b1;

    // ADDI x1, x0, 5
    push(32'h0, 32'h00500093);
    query();
    check_val("addi_en", DC2DP_en, 1);
    check_val("addi_op", DC2DP_opcode, 19);
    check_val("addi_rd", DC2DP_rd, 1);
    check_val("addi_imm", DC2DP_imm, 5);

    // BEQ with negative offset, then an all-ones illegal word
    push(32'h100, 32'hFE208EE3);
    push(32'h104, 32'hFFFFFFFF);
    query();
    check_val("beq_op", DC2DP_opcode, 5);
    check_val("beq_rs1", DC2DP_rs1, 1);
    check_val("beq_rs2", DC2DP_rs2, 2);
    check_val("beq_rd", DC2DP_rd, 0);
    check_val("beq_imm", DC2DP_imm, 32'hFFFFFFFC);
    query();
    check_val("ill_en", DC2DP_en, 1);
    check_val("ill_op", DC2DP_opcode, 0);
    check_val("ill_imm", DC2DP_imm, 0);

    // Query on empty queue, push arrives later
    query();
    idle();
    push(32'h200, 32'h00A00113);
    exp_lat = BYPASS ? 1 : 2;
    first = 0; pulses = 0;
    for (int k = 1; k <= 4; k++) begin
      if (DC2DP_en) begin
        pulses++;
        if (first == 0) first = k;
      end
      idle();
    end
    check_val("wait_latency", first, exp_lat);
    check_val("wait_pulses", pulses, 1);

    // Fill to capacity, overflow push, drain in order
    for (int i = 1; i <= 8; i++) begin
      push(32'h1000 + 32'(4 * i), rand_inst());
      check_val("full_at_count", DC2IF_full, i >= 7);
    end
    push(32'h2000, 32'h00500093);
    check_val("full_after_drop", DC2IF_full, 1);
    for (int i = 1; i <= 8; i++) begin
      query();
      check_val("drain_en", DC2DP_en, 1);
      check_val("drain_pc", DC2DP_pc, 32'h1000 + 32'(4 * i));
    end
    idle();

    // Clear with a same-cycle push and query
    push(32'h400, rand_inst()); push(32'h404, rand_inst()); push(32'h408, rand_inst());
    cycle(1'b1, 32'h40C, 32'h00500093, 1'b1, 1'b1, 1'b1);
    check_val("clr_en", DC2DP_en, 0);
    check_val("clr_full", DC2IF_full, 0);
    push(32'h300, 32'h00500093);
    query();
    check_val("post_clr_en", DC2DP_en, 1);
    check_val("post_clr_pc", DC2DP_pc, 32'h300);

    // rdy_in low freezes queue and outputs while a pulse is showing
    push(32'h500, rand_inst()); push(32'h504, rand_inst());
    query();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, $urandom, rand_inst(), 1'b1, i == 2, 1'b0);
    check_val("frozen_en", DC2DP_en, 1);
    check_val("frozen_pc", DC2DP_pc, 32'h500);
    query();
    check_val("thaw_pc", DC2DP_pc, 32'h504);

    random_cycles(250);

    // Asynchronous reset in the middle of traffic
    push(32'h600, rand_inst()); push(32'h604, rand_inst()); query();
    idle();
    #2;
    rst_in = 1'b0;
    #1;
    check_val("arst_en", DC2DP_en, 0);
    check_val("arst_pc", DC2DP_pc, 0);
    check_val("arst_op", DC2DP_opcode, 0);
    check_val("arst_imm", DC2DP_imm, 0);
    check_val("arst_full", DC2IF_full, 0);
    model_reset();
    @(posedge clk_in);
    #1;
    compare_all();
    #2;
    rst_in = 1'b1;
    query();
    idle();
    check_val("post_rst_empty", DC2DP_en, 0);

    random_cycles(250);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
